switch_allocator: RTL
=====================

// Module: switch_allocator
// PURPOSE
//  Packet-granular switch allocator for the 5-port router (L,N,E,W,S). Each output owns a
//  round-robin arbiter. A header flit wins an output and locks it until the tail flit is
//  transferred, or until a per-output stall watchdog releases it.
//  Drives the input-buffer pops and the crossbar select lines.
// PARAMETERS
//  NPORTS        5    number of ports; fixed at 5; index 0..4 = L,N,E,W,S
//  TIMEOUT_CYC   256  locked cycles with no transfer before forced release; 0 = watchdog off
//  CNT_W         12   width of the per-output watchdog counter
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   5       input i has a flit at its buffer head
//  in_flit_id   in   15      3b per input {i*3+:3}: 001 head, 010 body, 100 tail, 101 head+tail
//  in_dest      in   15      3b per input: destination output index; only sampled with a head flit
//  out_ready    in   5       output o / downstream can accept a flit this cycle
//  in_grant     out  5       pop strobe to input i's buffer; the flit is transferred this cycle
//  out_valid    out  5       output o carries a valid flit this cycle
//  xbar_sel     out  15      3b per output: selected input index; 3'b111 = idle
//  timeout_evt  out  5       1-cycle pulse: watchdog released output o
//  dest_err     out  5       1-cycle pulse: input i presented a head flit with in_dest > 4
// BEHAVIOUR
//  - Reset: all outputs free; rr_ptr[o] = 4, so input 0 has top priority; counters = 0.
//    in_grant, out_valid, timeout_evt and dest_err are 0; xbar_sel = all 3'b111.
//  - Request: input i requests output o when all of these hold:
//      in_valid[i], flit_id is 001 or 101, in_dest[i]==o, and i owns no output.
//  - Arbitration runs only on a free output. The winner is the first requester at or after
//    (rr_ptr+1) mod 5. On a win: owner[o]<=winner, locked[o]<=1, rr_ptr[o]<=winner (all registered).
//  - Allocation latency is 1 cycle: the header moves in the first cycle after the win.
//  - While locked:
//      xbar_sel[o] = owner
//      out_valid[o] = in_grant[owner] = in_valid[owner] & out_ready[o]   (combinational)
//  - Release: a transfer with flit_id 100 or 101 sets locked[o]<=0. The output is free next
//    cycle and re-arbitrates then, giving a 1-cycle bubble between packets. No bypass.
//  - Watchdog: cnt[o] increments each locked cycle with no transfer and clears on a transfer.
//    When cnt==TIMEOUT_CYC-1 with no transfer: release, pulse timeout_evt[o], cnt<=0.
//    Transfer and timeout in the same cycle: the transfer wins and no timeout fires.
//  - Non-head flits at an input that owns no output are never granted; they wait.
//  - dest_err: a head with in_dest>4 never requests and pulses dest_err[i] every cycle it is
//    presented.
//  - Reset mid-packet drops every lock at once. Flits already in flight are not recovered.
//  - An input owns at most 1 output. in_grant is one-hot per input by construction.
// STRUCTURE
//  - router_pkg: port index constants (P_L..P_S), flit id encodings (FLIT_HEAD/BODY/TAIL/
//    HEADTAIL), SEL_IDLE=3'b111, NPORTS.
//  - Sub-module rr_out_arbiter: 5 request bits, rr_ptr, one-hot grant plus encoded winner.
//    Instantiated once per output. Lock, owner and watchdog state live in the top level.
// TESTING
//  1 After reset, in_valid=00001, head, dest=2, out_ready=all 1:
//    cycle+1 xbar_sel[2]=0 and in_grant[0]=1.
//    Body then tail flits stream 1 per cycle. Output 2 is free the cycle after the tail.
//  2 Inputs 0,1,3 send heads to output 4 at the same time, 1-flit packets (101):
//    served in order 0, 1, 3, with 1 idle cycle between grants.
//    A repeat burst starts at input 4's slot, so input 0 is next after 3.
//  3 Input 1 locked to output 0, out_ready[0]=0 for 10 cycles: no in_grant[1], no timeout.
//    When out_ready returns, the flow resumes with no lost flit.
//  4 TIMEOUT_CYC=8, input 2 locked, in_valid[2]=0 after the header:
//    timeout_evt pulses after 8 idle cycles; the output is re-arbitrated next cycle.
//  5 Head with dest=6 on input 3: dest_err[3] pulses and no grant is given.
//    A body flit on an unlocked input gets no grant.
//  6 rst asserted mid-packet: next cycle xbar_sel is all idle, in_grant=0, and input 0
//    wins the next contention.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 5-port router: port indices, flit id encodings and crossbar idle code.
// Also provides small helpers that decode the head/tail meaning of a flit id.
package router_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_S = 3'd4;

    typedef enum logic [2:0] {
        FLIT_HEAD     = 3'b001,
        FLIT_BODY     = 3'b010,
        FLIT_TAIL     = 3'b100,
        FLIT_HEADTAIL = 3'b101
    } flit_id_e;

    localparam logic [2:0] SEL_IDLE = 3'b111;

    function automatic logic isHead(input logic [2:0] id);
        return (id == FLIT_HEAD) || (id == FLIT_HEADTAIL);
    endfunction

    function automatic logic isTail(input logic [2:0] id);
        return (id == FLIT_TAIL) || (id == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/rr_out_arbiter.sv
// Round-robin arbiter owned by one router output; picks the first requester after the last winner.
// The pointer only moves when a grant is actually issued.
module rr_out_arbiter
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [NPORTS-1:0] req_i,
    output logic [NPORTS-1:0] gnt_o,
    output logic [2:0]        winner_o
);

    logic [2:0] rrPtr_q;
    logic [2:0] rrPtr_d;
    int         idx;

    // Scan starts one past the previous winner so it has lowest priority next time.
    always_comb begin
        gnt_o    = '0;
        winner_o = SEL_IDLE;
        idx      = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(rrPtr_q) + k) % NPORTS;
            if (enable_i && (gnt_o == '0) && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                winner_o   = 3'(idx);
            end
        end
        rrPtr_d = (gnt_o != '0) ? winner_o : rrPtr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q <= 3'd4;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Packet-granular switch allocator: each output locks to one input from header to tail,
// with a per-output stall watchdog that can force the lock open.
module switch_allocator
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_valid,
    input  logic [14:0] in_flit_id,
    input  logic [14:0] in_dest,
    input  logic [4:0]  out_ready,
    output logic [4:0]  in_grant,
    output logic [4:0]  out_valid,
    output logic [14:0] xbar_sel,
    output logic [4:0]  timeout_evt,
    output logic [4:0]  dest_err
);

    logic [NPORTS-1:0]             locked_q, locked_d;
    logic [NPORTS-1:0][2:0]        owner_q, owner_d;
    logic [NPORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [NPORTS-1:0][2:0]        flitId, dest;
    logic [NPORTS-1:0]             ownsAny, xfer, tailXfer, timeout;
    logic [NPORTS-1:0][NPORTS-1:0] req, arbGnt;
    logic [NPORTS-1:0][2:0]        arbWinner;

    assign flitId = in_flit_id;
    assign dest   = in_dest;

    // Requests are formed per output (req[o][i]); an input already holding an output stays quiet.
    always_comb begin
        ownsAny  = '0;
        req      = '0;
        dest_err = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (locked_q[o] && owner_q[o] == 3'(i)) ownsAny[i] = 1'b1;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (in_valid[i] && isHead(flitId[i])) begin
                if (dest[i] > 3'(NPORTS - 1)) begin
                    dest_err[i] = 1'b1;
                end else if (!ownsAny[i]) begin
                    for (int o = 0; o < NPORTS; o++) begin
                        if (dest[i] == 3'(o)) req[o][i] = 1'b1;
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : gen_arb
            rr_out_arbiter u_arb (
                .clk      (clk),
                .rst      (rst),
                .enable_i (~locked_q[g]),
                .req_i    (req[g]),
                .gnt_o    (arbGnt[g]),
                .winner_o (arbWinner[g])
            );
        end
    endgenerate

    // Locked outputs steer the crossbar and pop the owner whenever both ends are ready.
    always_comb begin
        in_grant    = '0;
        out_valid   = '0;
        xbar_sel    = {NPORTS{SEL_IDLE}};
        xfer        = '0;
        tailXfer    = '0;
        timeout     = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (locked_q[o] && owner_q[o] == 3'(i)) begin
                    xbar_sel[o*3 +: 3] = 3'(i);
                    if (in_valid[i] && out_ready[o]) begin
                        xfer[o]      = 1'b1;
                        in_grant[i]  = 1'b1;
                        out_valid[o] = 1'b1;
                        tailXfer[o]  = isTail(flitId[i]);
                    end
                end
            end
            timeout[o] = (TIMEOUT_CYC != 0) && locked_q[o] && !xfer[o] &&
                         (cnt_q[o] == CNT_W'(TIMEOUT_CYC - 1));
        end
        timeout_evt = timeout;
    end

    // A transfer always clears the watchdog, so it takes precedence over a timeout.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        for (int o = 0; o < NPORTS; o++) begin
            if (!locked_q[o]) begin
                cnt_d[o] = '0;
                if (arbGnt[o] != '0) begin
                    locked_d[o] = 1'b1;
                    owner_d[o]  = arbWinner[o];
                end
            end else if (tailXfer[o] || timeout[o]) begin
                locked_d[o] = 1'b0;
                cnt_d[o]    = '0;
            end else if (xfer[o]) begin
                cnt_d[o] = '0;
            end else begin
                cnt_d[o] = cnt_q[o] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
